// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the core load/store port.
// Request/response valid/ready handshakes around a configurable wait, RISC-V byte/half/word access.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int CNT_W = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept, go_resp;

  logic              lat_write;
  logic [2:0]        lat_funct3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              a_write;
  logic [2:0]        a_funct3;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-3:0] idx;
  logic [31:0]       word, load_val, st_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        st_be;
  logic              misaligned, illegal, err;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go_resp = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY == 0) begin
          state_n = RESP;
          go_resp = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = CNT_W'(LATENCY);
        end
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge, so it must see the live request.
  always_comb begin
    if (state == IDLE) begin
      a_write  = req_write;
      a_funct3 = req_funct3;
      a_addr   = req_addr;
      a_wdata  = req_wdata;
    end else begin
      a_write  = lat_write;
      a_funct3 = lat_funct3;
      a_addr   = lat_addr;
      a_wdata  = lat_wdata;
    end
  end

  always_comb begin
    idx    = a_addr[ADDR_W-1:2];
    word   = mem[idx];
    byte_v = word[{a_addr[1:0], 3'b000} +: 8];
    half_v = a_addr[1] ? word[31:16] : word[15:0];

    case (a_funct3[1:0])
      2'b01:   misaligned = a_addr[0];
      2'b10:   misaligned = |a_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (a_write) illegal = !(a_funct3 inside {3'b000, 3'b001, 3'b010});
    else         illegal = a_funct3 inside {3'b011, 3'b110, 3'b111};
    err = misaligned || illegal;

    case (a_funct3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = word;
    endcase

    case (a_funct3[1:0])
      2'b00: begin
        st_data = {4{a_wdata[7:0]}};
        st_be   = 4'b0001 << a_addr[1:0];
      end
      2'b01: begin
        st_data = {2{a_wdata[15:0]}};
        st_be   = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = a_wdata;
        st_be   = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (go_resp && a_write && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      lat_write  <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_write  <= req_write;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
      end
      if (go_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (a_write || err) ? '0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance and one LATENCY=0 instance
// sharing request fields, each with its own req_valid.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid0;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; request fields are scrambled right after acceptance to prove they were latched.
  task automatic txn(input bit sel, input string tag, input logic wr, input logic [2:0] f3,
                     input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(sel ? req_ready0 : req_ready), 32'd1);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = 1'b0;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    req_write  = ~wr;
    req_funct3 = 3'b111;
    req_addr   = addr ^ 8'h04;
    req_wdata  = ~wd;
    n = 1;
    while (!(sel ? rsp_valid0 : rsp_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency_edges"}, 32'(n), sel ? 32'd1 : 32'd3);
    check({tag, " rdata"}, sel ? rsp_rdata0 : rsp_rdata, exp_rd);
    check({tag, " err"}, 32'(sel ? rsp_err0 : rsp_err), 32'(exp_err));
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " valid_after_hs"}, 32'(sel ? rsp_valid0 : rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #3;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1;

    txn(0, "SW 10", 1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 0);
    txn(0, "LW 10", 0, 3'b010, 8'h10, 32'h0, 32'hDEADBEEF, 0);
    txn(0, "LB 13", 0, 3'b000, 8'h13, 32'h0, 32'hFFFFFFDE, 0);
    txn(0, "LBU 13", 0, 3'b100, 8'h13, 32'h0, 32'h000000DE, 0);
    txn(0, "LH 12", 0, 3'b001, 8'h12, 32'h0, 32'hFFFFDEAD, 0);
    txn(0, "LHU 10", 0, 3'b101, 8'h10, 32'h0, 32'h0000BEEF, 0);
    txn(0, "SB 11", 1, 3'b000, 8'h11, 32'h00000055, 32'h0, 0);
    txn(0, "LW after SB", 0, 3'b010, 8'h10, 32'h0, 32'hDEAD55EF, 0);
    txn(0, "LB 11", 0, 3'b000, 8'h11, 32'h0, 32'h00000055, 0);
    txn(0, "SH 12", 1, 3'b001, 8'h12, 32'h00001234, 32'h0, 0);
    txn(0, "LW after SH", 0, 3'b010, 8'h10, 32'h0, 32'h123455EF, 0);
    txn(0, "LW 12 misaligned", 0, 3'b010, 8'h12, 32'h0, 32'h0, 1);
    txn(0, "SH 11 misaligned", 1, 3'b001, 8'h11, 32'hFFFFFFFF, 32'h0, 1);
    txn(0, "SW illegal f3", 1, 3'b100, 8'h10, 32'h0, 32'h0, 1);
    txn(0, "LW after bad stores", 0, 3'b010, 8'h10, 32'h0, 32'h123455EF, 0);
    txn(0, "load f3 011", 0, 3'b011, 8'h10, 32'h0, 32'h0, 1);

    // Backpressure: hold the response while a competing store is offered.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 8'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 32'h0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp latency_edges", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rdata", rsp_rdata, 32'h123455EF);
      check("bp err", 32'(rsp_err), 32'd0);
      check("bp req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    txn(0, "LW after bp", 0, 3'b010, 8'h10, 32'h0, 32'h123455EF, 0);

    // Asynchronous reset while a response is held.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 8'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("pre-reset rdata", rsp_rdata, 32'h123455EF);
    #2 rst = 1'b0;
    #1;
    check("async reset req_ready", 32'(req_ready), 32'd1);
    check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("async reset rsp_rdata", rsp_rdata, 32'd0);
    check("async reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Store discarded by reset during WAIT.
    txn(0, "SW 20 old", 1, 3'b010, 8'h20, 32'h0BADC0DE, 32'h0, 0);
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 8'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("wait reset req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b1;
    txn(0, "LW 20 after abort", 0, 3'b010, 8'h20, 32'h0, 32'h0BADC0DE, 0);

    txn(1, "L0 SW 10", 1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 0);
    txn(1, "L0 LW 10", 0, 3'b010, 8'h10, 32'h0, 32'hDEADBEEF, 0);
    txn(1, "L0 LH 12", 0, 3'b001, 8'h12, 32'h0, 32'hFFFFDEAD, 0);
    txn(1, "L0 LW 12 misaligned", 0, 3'b010, 8'h12, 32'h0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU load/store port, the other end of the interface that the core drives with address, funct3, store data and read/write strobes.
- Accepts one request at a time over a valid/ready handshake and waits a parameterised number of cycles.
- Performs byte, half or word access with RISC-V sign/zero extension, then returns read data and an error flag over a second valid/ready handshake.
- Used by the pipelined core as a multi-cycle data memory.

Parameters:
- ADDR_W, 8, byte-address width; memory holds 2^(ADDR_W-2) 32-bit words.
- LATENCY, 2, wait cycles between request acceptance and response (0 allowed).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte/half in low bits).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal funct3.

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE.
- Accept on an edge with req_valid & req_ready. On that edge latch write, funct3, addr and wdata.
- Transition on accept: to WAIT with counter = LATENCY, or directly to RESP if LATENCY = 0.
- WAIT: the counter decrements each edge. When the counter is 1, the next edge moves to RESP.
- rsp_valid rises exactly LATENCY+1 edges after the accept edge.
- The memory access occurs on the edge entering RESP:
  - Stores commit to the array on that edge.
  - Loads capture the word into rsp_rdata on that edge.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until an edge with rsp_ready = 1, which returns the FSM to IDLE.
- No new request is accepted on the same edge as the response handshake; back-to-back throughput is one request per LATENCY+2 cycles.
- Loads (funct3):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011, 110, 111: illegal.
- Stores (funct3):
  - 000 SB: write only the byte lane addr[1:0].
  - 001 SH: write the half lane addr[1].
  - 010 SW: full word.
  - All others: illegal.
- Lane selection is little-endian: byte 0 = bits 7:0.
- Misaligned requests: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
- Error handling (misaligned or illegal): rsp_err = 1, rsp_rdata = 0, memory unchanged. Full latency still applies.
- Word index = addr[ADDR_W-1:2]. All addresses map in range; there is no out-of-range error.
- Reset (rst low, asynchronous):
  - State returns to IDLE, counter = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - A store still in WAIT is discarded.
  - Array contents are not reset.
- Inputs are ignored outside the accept edge; changes to req_* during WAIT or RESP have no effect.

Test Plan:
- Reset: assert rst = 0 mid-idle → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 immediately, without a clock edge.
- Word round trip, LATENCY = 2:
  - SW 0xDEADBEEF to 0x10 → rsp_valid on the 3rd edge after accept, rsp_err = 0, rsp_rdata = 0.
  - Then LW 0x10 → rsp_rdata = 0xDEADBEEF.
- Extension, with 0x10 holding 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- Partial store: SB wdata 0x00000055 to 0x11, then LW 0x10 → 0xDEAD55EF. SH 0x1234 to 0x12, then LW 0x10 → 0x123455EF.
- Errors:
  - LW 0x12 → rsp_err = 1, rdata = 0.
  - SH to 0x11 → rsp_err = 1, and a following LW 0x10 is unchanged.
  - Load funct3 = 011 → rsp_err = 1.
- Backpressure and reset:
  - Hold rsp_ready = 0 for 5 cycles in RESP → rsp_rdata/rsp_err stable, req_ready = 0, a concurrent req_valid is not accepted.
  - SW 0xCAFEF00D to 0x20, then pull rst low during WAIT → LW 0x20 after reset returns the old contents.
  - Repeat the round-trip scenario with LATENCY = 0 → rsp_valid on the 1st edge after accept.
